// File: rtl/capture_buffer_pkg.sv
// Shared definitions for the capture buffer: FSM state encoding, Wishbone
// register byte offsets and CTRL command bit positions.
package capture_buffer_pkg;

  // State values are visible in STATUS, so the encoding is fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_e;

  localparam logic [13:0] REG_CTRL     = 14'h0000;
  localparam logic [13:0] REG_STATUS   = 14'h0004;
  localparam logic [13:0] REG_TRIGADDR = 14'h0008;

  localparam int CTRL_ARM       = 0;
  localparam int CTRL_SOFT_TRIG = 1;

  localparam int BEAT_W = 128;

endpackage

// File: rtl/capture_buffer_ram.sv
// Simple dual-port DEPTH x W RAM: one synchronous write port, one read port
// with a single registered read stage (rdata valid the cycle after raddr).
// A read and write to the same address in one cycle returns the old data.
//   clk    : clock
//   we     : write enable, waddr/wdata : write port
//   raddr  : read address, rdata : registered read data
module capture_buffer_ram #(
  parameter  int DEPTH = 1024,
  parameter  int W     = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_buffer.sv
// Triggered capture buffer. Beats from a never-stalled 128-bit stream are
// written into a circular RAM once armed; after PRETRIG beats of history the
// block waits for a hardware or soft trigger, then stores DEPTH-PRETRIG more
// beats (trigger beat included) and stops. Wishbone exposes CTRL/STATUS/
// TRIGADDR and a read window (adr[14]=1) indexed relative to the trigger so
// index PRETRIG is always the trigger beat.
//   wb_clk_i/wb_rst_i          : clock, synchronous active-high reset
//   wb_cyc_i..wb_sel_i         : Wishbone classic slave inputs
//   wb_ack_o, wb_dat_o         : Wishbone ack / read data
//   s_axis_tdata/tvalid        : capture stream
//   trigger, capture_enable    : hardware trigger and trigger gate
//   capture_waiting            : armed with full pre-trigger history
module capture_buffer
  import capture_buffer_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int PRETRIG = 256
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [14:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic              wb_ack_o,
  output logic [31:0]       wb_dat_o,
  input  logic [BEAT_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              trigger,
  input  logic              capture_enable,
  output logic              capture_waiting
);

  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = AW + 1;
  localparam int POST_BEATS = DEPTH - PRETRIG;

  cap_state_e        state, state_nxt;
  logic [AW-1:0]     wptr, trig_addr;
  logic [CW-1:0]     fill_cnt, post_cnt;
  logic              soft_pend;

  logic              acc, ctrl_wr, arm, soft_set;
  logic              beat, trig_hit;
  logic              mrd_pend;
  logic [1:0]        mrd_word;
  logic [31:0]       reg_rdata;
  logic [AW-1:0]     ram_raddr;
  logic [BEAT_W-1:0] ram_rdata;

  // Byte selects and sub-word address bits play no part in decode.
  logic unused_ok;
  assign unused_ok = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:2]};

  // A new access is taken only when no ack is on the bus and no memory read
  // is in flight, so a held strobe is never accepted twice.
  assign acc      = wb_cyc_i && wb_stb_i && !wb_ack_o && !mrd_pend;
  assign ctrl_wr  = acc && wb_we_i && !wb_adr_i[14] &&
                    (wb_adr_i[13:2] == REG_CTRL[13:2]);
  assign arm      = ctrl_wr && wb_dat_i[CTRL_ARM];
  assign soft_set = ctrl_wr && wb_dat_i[CTRL_SOFT_TRIG] && !arm;

  assign beat     = s_axis_tvalid &&
                    (state == ST_FILL || state == ST_ARMED || state == ST_POST);
  assign trig_hit = (state == ST_ARMED) && s_axis_tvalid && capture_enable &&
                    (trigger || soft_pend);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FILL:
        if (PRETRIG == 0 || (beat && fill_cnt == CW'(PRETRIG - 1)))
          state_nxt = ST_ARMED;
      ST_ARMED:
        if (trig_hit) state_nxt = (POST_BEATS == 1) ? ST_DONE : ST_POST;
      ST_POST:
        if (beat && post_cnt == CW'(POST_BEATS - 1)) state_nxt = ST_DONE;
      default: ;
    endcase
    // Arming restarts the capture from any state and beats a same-cycle trigger.
    if (arm) state_nxt = ST_FILL;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state           <= ST_IDLE;
      wptr            <= '0;
      trig_addr       <= '0;
      fill_cnt        <= '0;
      post_cnt        <= '0;
      soft_pend       <= 1'b0;
      capture_waiting <= 1'b0;
    end else begin
      state           <= state_nxt;
      capture_waiting <= (state_nxt == ST_ARMED);
      if (beat) wptr <= wptr + AW'(1);
      if (arm)                          fill_cnt <= '0;
      else if (beat && state == ST_FILL) fill_cnt <= fill_cnt + CW'(1);
      // post_cnt counts POST beats including the trigger beat.
      if (arm)                          post_cnt <= '0;
      else if (trig_hit)                post_cnt <= CW'(1);
      else if (beat && state == ST_POST) post_cnt <= post_cnt + CW'(1);
      if (trig_hit && !arm) trig_addr <= wptr;
      if (arm)           soft_pend <= 1'b0;
      else if (soft_set) soft_pend <= 1'b1;
      else if (trig_hit) soft_pend <= 1'b0;
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (wb_adr_i[13:2] == REG_STATUS[13:2])
      reg_rdata = {29'b0, state};
    else if (wb_adr_i[13:2] == REG_TRIGADDR[13:2])
      reg_rdata = 32'(trig_addr);
  end

  // Window index 0 is PRETRIG beats before the trigger; wraps mod DEPTH.
  assign ram_raddr = AW'(32'(trig_addr) - 32'(PRETRIG) + 32'(wb_adr_i[13:4]));

  // Register accesses and memory writes ack the cycle after acceptance; memory
  // reads spend one extra cycle in the RAM output register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      mrd_pend <= 1'b0;
      mrd_word <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      if (mrd_pend) begin
        wb_ack_o <= 1'b1;
        wb_dat_o <= ram_rdata[{mrd_word, 5'b0} +: 32];
        mrd_pend <= 1'b0;
      end else if (acc) begin
        if (wb_adr_i[14] && !wb_we_i) begin
          mrd_pend <= 1'b1;
          mrd_word <= wb_adr_i[3:2];
        end else begin
          wb_ack_o <= 1'b1;
          if (!wb_we_i) wb_dat_o <= reg_rdata;
        end
      end
    end
  end

  capture_buffer_ram #(
    .DEPTH (DEPTH),
    .W     (BEAT_W)
  ) u_ram (
    .clk   (wb_clk_i),
    .we    (beat && !wb_rst_i),
    .waddr (wptr),
    .wdata (s_axis_tdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_capture_buffer.sv
// Bench for capture_buffer: directed capture scenarios followed by randomized
// captures, all checked against a count-based model of the capture rules.
module tb_capture_buffer;
  import capture_buffer_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int PRETRIG = 256;
  localparam int POSTB   = DEPTH - PRETRIG;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b0;
  logic         wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [14:0]  wb_adr_i = '0;
  logic [31:0]  wb_dat_i = '0;
  logic [3:0]   wb_sel_i = 4'hf;
  logic         wb_ack_o;
  logic [31:0]  wb_dat_o;
  logic [127:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         trigger = 1'b0, capture_enable = 1'b0;
  logic         capture_waiting;

  capture_buffer #(.DEPTH(DEPTH), .PRETRIG(PRETRIG)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
    .wb_dat_o(wb_dat_o), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .trigger(trigger),
    .capture_enable(capture_enable), .capture_waiting(capture_waiting)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0, errors = 0;

  // Model: beats counted since arm, position of trigger in that count.
  bit [127:0] m_mem [DEPTH];
  bit         m_wr  [DEPTH];
  bit         m_run, m_soft;
  int         m_k, m_trig_k = -1, m_wptr, m_trig_addr;
  bit         arm_now, soft_now;

  int         beat_no = 0;
  int         acc_beat;
  logic [31:0] salt = '0;
  bit         rand_mode = 0;
  logic [31:0] rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 idle, 1 filling, 2 armed, 3 post-trigger, 4 done
  function automatic int m_status();
    if (!m_run) return 0;
    if (m_trig_k < 0) return (m_k < PRETRIG) ? 1 : 2;
    return (m_k - m_trig_k < POSTB) ? 3 : 4;
  endfunction

  function automatic logic [31:0] m_rd(input int idx, input int w);
    int a;
    a = ((m_trig_addr - PRETRIG + idx) % DEPTH + DEPTH) % DEPTH;
    return m_mem[a][32*w +: 32];
  endfunction

  function automatic bit m_known(input int idx);
    return m_wr[((m_trig_addr - PRETRIG + idx) % DEPTH + DEPTH) % DEPTH];
  endfunction

  task automatic model_edge();
    int st;
    bit wr, hit;
    if (wb_rst_i) begin
      m_run = 0; m_soft = 0; m_k = 0; m_trig_k = -1; m_wptr = 0; m_trig_addr = 0;
      return;
    end
    st  = m_status();
    wr  = s_axis_tvalid && st >= 1 && st <= 3;
    hit = st == 2 && s_axis_tvalid && capture_enable && (trigger || m_soft);
    if (arm_now) begin
      m_run = 1; m_k = 0; m_trig_k = -1; m_soft = 0;
    end else begin
      if (hit) begin m_trig_k = m_k; m_trig_addr = m_wptr; end
      if (wr) m_k++;
      if (soft_now) m_soft = 1;
      else if (hit) m_soft = 0;
    end
    if (wr) begin
      m_mem[m_wptr] = s_axis_tdata;
      m_wr[m_wptr]  = 1;
      m_wptr        = (m_wptr + 1) % DEPTH;
    end
  endtask

  // One clock: present the beat, advance the model, sample after the edge.
  task automatic tick();
    if (rand_mode) s_axis_tdata = {$urandom, $urandom, $urandom, $urandom};
    else           s_axis_tdata = {4{salt | 32'(beat_no)}};
    model_edge();
    @(posedge wb_clk_i); #1;
    if (arm_now) beat_no = 0;
    else if (s_axis_tvalid) beat_no++;
    chk("capture_waiting", {31'b0, capture_waiting}, (m_status() == 2) ? 32'd1 : 32'd0);
  endtask

  task automatic run_to(input int n);
    for (int i = 0; i < 6000 && beat_no < n; i++) tick();
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1; tick(); wb_rst_i = 1'b0;
  endtask

  task automatic wb_write(input logic [14:0] adr, input logic [31:0] dat);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = adr; wb_dat_i = dat;
    if (!adr[14] && adr[13:2] == REG_CTRL[13:2]) begin
      arm_now  = dat[CTRL_ARM];
      soft_now = dat[CTRL_SOFT_TRIG] && !dat[CTRL_ARM];
    end
    acc_beat = beat_no;
    tick();
    arm_now = 0; soft_now = 0;
    chk("wr_ack", {31'b0, wb_ack_o}, 32'd1);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    tick();
    chk("wr_ack_drop", {31'b0, wb_ack_o}, 32'd0);
  endtask

  task automatic wb_read(input logic [14:0] adr, input int lat, output logic [31:0] data);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = adr;
    tick();
    if (lat == 2) begin
      chk("mrd_ack_early", {31'b0, wb_ack_o}, 32'd0);
      tick();
    end
    chk("rd_ack", {31'b0, wb_ack_o}, 32'd1);
    data = wb_dat_o;
    wb_cyc_i = 0; wb_stb_i = 0;
    tick();
    chk("rd_ack_drop", {31'b0, wb_ack_o}, 32'd0);
  endtask

  task automatic rd_reg(input string tag, input logic [13:0] off, input logic [31:0] exp);
    logic [31:0] d;
    wb_read({1'b0, off}, 1, d);
    chk(tag, d, exp);
  endtask

  task automatic rd_mem(input string tag, input int idx, input int w, input logic [31:0] exp);
    logic [31:0] d;
    wb_read({1'b1, 10'(idx), 2'(w), 2'b00}, 2, d);
    chk(tag, d, exp);
  endtask

  initial begin
    // Reset state
    do_reset(); tick();
    chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    rd_reg("rst_status", REG_STATUS, 32'd0);
    rd_reg("rst_trigaddr", REG_TRIGADDR, 32'd0);
    rd_reg("unmapped", 14'h0010, 32'd0);
    wb_write(15'h4000, 32'hdeadbeef);  // memory write: acked, discarded

    // Scenario A: arm at beat 0, trigger at 600
    do_reset(); salt = 32'h0A00_0000;
    s_axis_tvalid = 1; capture_enable = 1; trigger = 0;
    wb_write({1'b0, REG_CTRL}, 32'h1);
    run_to(255);
    chk("A_wait_before", {31'b0, capture_waiting}, 32'd0);
    tick();
    chk("A_wait_after", {31'b0, capture_waiting}, 32'd1);
    rd_reg("A_status_armed", REG_STATUS, 32'd2);
    run_to(600); trigger = 1; tick(); trigger = 0;
    run_to(1366);
    rd_reg("A_status_post", REG_STATUS, 32'd3);
    rd_reg("A_status_done", REG_STATUS, 32'd4);
    rd_reg("A_trigaddr", REG_TRIGADDR, 32'd600);
    rd_mem("A_idx256", 256, 0, salt | 32'd600);
    rd_mem("A_idx0", 0, 2, salt | 32'd344);
    rd_mem("A_idx1023", 1023, 3, salt | 32'd1367);

    // Scenario B: trigger in FILL ignored, later trigger taken
    do_reset(); salt = 32'h0B00_0000;
    wb_write({1'b0, REG_CTRL}, 32'h1);
    run_to(100); trigger = 1; tick(); trigger = 0;
    run_to(700); trigger = 1; tick(); trigger = 0;
    run_to(700 + POSTB);
    rd_reg("B_status", REG_STATUS, 32'd4);
    rd_reg("B_trigaddr", REG_TRIGADDR, 32'd700);
    rd_mem("B_idx256", 256, 1, salt | 32'd700);

    // Scenario C: trigger after wptr wraps
    do_reset(); salt = 32'h0C00_0000;
    wb_write({1'b0, REG_CTRL}, 32'h1);
    run_to(1100); trigger = 1; tick(); trigger = 0;
    run_to(1100 + POSTB);
    rd_reg("C_status", REG_STATUS, 32'd4);
    rd_reg("C_trigaddr", REG_TRIGADDR, 32'd76);
    rd_mem("C_idx0", 0, 0, salt | 32'd844);

    // Scenario D: disabled hardware trigger, then soft trigger
    do_reset(); salt = 32'h0D00_0000;
    capture_enable = 0; trigger = 1;
    wb_write({1'b0, REG_CTRL}, 32'h1);
    run_to(300);
    rd_reg("D_status_gated", REG_STATUS, 32'd2);
    trigger = 0; capture_enable = 1; tick();
    wb_write({1'b0, REG_CTRL}, 32'h2);
    rd_reg("D_trigaddr", REG_TRIGADDR, 32'((acc_beat + 1) % DEPTH));
    rd_reg("D_status_post", REG_STATUS, 32'd3);

    // Scenario E: arm beats trigger, tvalid=0 trigger ignored, reset in POST
    do_reset(); salt = 32'h0E00_0000;
    wb_write({1'b0, REG_CTRL}, 32'h1);
    run_to(260);
    trigger = 1;
    wb_write({1'b0, REG_CTRL}, 32'h1);
    trigger = 0;
    rd_reg("E_arm_wins", REG_STATUS, 32'd1);
    run_to(258);
    s_axis_tvalid = 0; trigger = 1;
    tick(); tick(); tick();
    rd_reg("E_novalid", REG_STATUS, 32'd2);
    s_axis_tvalid = 1; trigger = 0;
    run_to(400); trigger = 1; tick(); trigger = 0;
    rd_reg("E_trigaddr", REG_TRIGADDR, 32'(m_trig_addr));
    run_to(450);
    acc_beat = m_wptr;  // slot the reset-edge beat would land in
    do_reset();
    chk("E_rst_wait", {31'b0, capture_waiting}, 32'd0);
    rd_reg("E_rst_status", REG_STATUS, 32'd0);
    rd_mem("E_no_write", (acc_beat + PRETRIG) % DEPTH, 0, m_mem[acc_beat][31:0]);
    wb_write({1'b0, REG_CTRL}, 32'h1);
    run_to(256); trigger = 1; tick(); trigger = 0;
    rd_reg("E_rearm_trigaddr", REG_TRIGADDR, 32'd256);

    // Randomized captures
    for (int it = 0; it < 3; it++) begin
      do_reset(); rand_mode = 1; s_axis_tvalid = 1; capture_enable = 1;
      wb_write({1'b0, REG_CTRL}, 32'h1);
      for (int c = 0; c < 5000 && m_status() != 4; c++) begin
        s_axis_tvalid  = ($urandom_range(0, 9) < 7);
        trigger        = ($urandom_range(0, 99) == 0);
        capture_enable = ($urandom_range(0, 3) != 0);
        if (c == 500 + it * 150) wb_write({1'b0, REG_CTRL}, 32'h2);
        else tick();
      end
      trigger = 0;
      chk("R_done", 32'(m_status()), 32'd4);
      rd_reg("R_status", REG_STATUS, 32'(m_status()));
      rd_reg("R_trigaddr", REG_TRIGADDR, 32'(m_trig_addr));
      for (int r = 0; r < 8; r++) begin
        int idx, w;
        idx = $urandom_range(0, DEPTH - 1);
        w   = $urandom_range(0, 3);
        if (r == 0) idx = PRETRIG;
        if (m_known(idx)) rd_mem("R_mem", idx, w, m_rd(idx, w));
      end
      rand_mode = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
